// File: rtl/imem_loader.sv
// Byte-stream program loader: receives a length-prefixed little-endian byte stream,
// packs it into 32-bit words and writes them to instruction memory, then releases the core.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned MEM_BYTES = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_en,
  output logic        rd_wr,
  output logic [31:0] write_addr,
  output logic [31:0] write_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [2:0]  state_dbg
);

  // Host handshake: a byte moves on a rising edge where in_valid & in_ready are both 1.
  // in_ready is decoded from the registered state only, so it never depends on in_valid.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [31:0] MAX_WORDS = (32'(MEM_BYTES) - BASE_ADDR) >> 2;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q;
  logic [23:0] len_q;
  logic [31:0] words_left_q;
  logic        xfer;
  logic        last_byte;
  logic [31:0] len_word;

  assign xfer      = in_valid & in_ready;
  assign last_byte = xfer & (byte_cnt_q == 2'd3);
  // The fourth length byte is still on the bus when the length is evaluated.
  assign len_word  = {in_data, len_q};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_LEN;
      S_LEN: begin
        if (last_byte) begin
          if (len_word == 32'd0)          state_d = S_DONE;
          else if (len_word > MAX_WORDS)  state_d = S_ERR;
          else                            state_d = S_DATA;
        end
      end
      S_DATA:  if (last_byte) state_d = S_WRITE;
      S_WRITE: state_d = (words_left_q == 32'd1) ? S_DONE : S_DATA;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt_q   <= 2'd0;
      len_q        <= 24'd0;
      words_left_q <= 32'd0;
      write_addr   <= BASE_ADDR;
      write_data   <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            byte_cnt_q <= 2'd0;
            write_addr <= BASE_ADDR;
          end
        end
        S_LEN: begin
          if (xfer) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            len_q      <= {in_data, len_q[23:8]};
            if (byte_cnt_q == 2'd3) words_left_q <= len_word;
          end
        end
        S_DATA: begin
          // Shifting in from the top leaves the first byte of the word in [7:0].
          if (xfer) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            write_data <= {in_data, write_data[31:8]};
          end
        end
        S_WRITE: begin
          write_addr   <= write_addr + 32'd4;
          words_left_q <= words_left_q - 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (state_q == S_LEN) || (state_q == S_DATA);
  assign mem_en     = (state_q == S_WRITE);
  assign rd_wr      = (state_q != S_WRITE);
  assign cpu_hold   = (state_q != S_DONE);
  assign load_done  = (state_q == S_DONE);
  assign load_error = (state_q == S_ERR);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives byte streams, tracks memory writes against
// an expected queue and a memory image, and checks handshake and status outputs.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mem_en, rd_wr, cpu_hold, load_done, load_error;
  logic [31:0] write_addr, write_data;
  logic [2:0]  state_dbg;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_LEN = 3'd1, ST_DATA = 3'd2,
                         ST_WRITE = 3'd3, ST_DONE = 3'd4, ST_ERR = 3'd5;
  // {in_ready, mem_en, rd_wr, cpu_hold, load_done, load_error}
  localparam logic [5:0] F_IDLE = 6'b001100, F_RX = 6'b101100, F_WRITE = 6'b010100,
                         F_DONE = 6'b001010, F_ERR = 6'b001101;

  int          tests_run = 0;
  int          failures  = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          last_wr_cyc = -1;
  bit          check_gap = 1'b0;
  logic [63:0] exp_q[$];
  logic [31:0] mem_img[0:15];
  int          saved_cnt;

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_en(mem_en), .rd_wr(rd_wr), .write_addr(write_addr),
    .write_data(write_data), .cpu_hold(cpu_hold), .load_done(load_done),
    .load_error(load_error), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic [5:0] exp);
    check(tag, 64'({in_ready, mem_en, rd_wr, cpu_hold, load_done, load_error}), 64'(exp));
  endtask

  task automatic check_state(input string tag, input logic [2:0] exp);
    check(tag, 64'(state_dbg), 64'(exp));
  endtask

  // Write monitor: each WRITE state lasts one cycle, so one falling edge sees it.
  always @(negedge clk) begin
    if (rst && mem_en) begin
      check("wr_rd_wr", 64'(rd_wr), 64'd0);
      check("wr_in_ready", 64'(in_ready), 64'd0);
      check("wr_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("wr_word", {write_addr, write_data}, exp_q.pop_front());
      mem_img[write_addr[5:2]] = write_data;
      wr_cnt++;
      if (check_gap && last_wr_cyc >= 0) check("wr_gap", 64'(cyc - last_wr_cyc), 64'd5);
      last_wr_cyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called on a falling edge; returns on the falling edge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("byte_timeout", 64'(n), 64'd0);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

  initial begin
    for (int i = 0; i < 16; i++) mem_img[i] = 32'h0;
    #2 rst = 1'b0;
    @(negedge clk);
    check_flags("rst_flags", F_IDLE);
    check_state("rst_state", ST_IDLE);
    check("rst_addr", 64'(write_addr), 64'h0);
    check("rst_data", 64'(write_data), 64'h0);
    rst = 1'b1;
    tick(1);

    // 1: single word
    pulse_start();
    check_flags("t1_len_flags", F_RX);
    check_state("t1_len_state", ST_LEN);
    exp_q.push_back({32'h0, 32'hDEADBEEF});
    send_word(32'd1);
    check_state("t1_data_state", ST_DATA);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    in_valid = 1'b0;
    check_flags("t1_write_flags", F_WRITE);
    check("t1_write_word", {write_addr, write_data}, {32'h0, 32'hDEADBEEF});
    tick(1);
    check_flags("t1_done_flags", F_DONE);
    check_state("t1_done_state", ST_DONE);
    check("t1_wr_cnt", 64'(wr_cnt), 64'd1);

    // 2: three words back to back, restart from DONE
    pulse_start();
    check_flags("t6_done_restart", F_RX);
    check("t2_addr_reload", 64'(write_addr), 64'h0);
    exp_q.push_back({32'h0, 32'h13121110});
    exp_q.push_back({32'h4, 32'h17161514});
    exp_q.push_back({32'h8, 32'h1B1A1918});
    check_gap = 1'b1;
    last_wr_cyc = -1;
    send_word(32'd3);
    for (int i = 0; i < 12; i++) send_byte(8'(8'h10 + i));
    in_valid = 1'b0;
    check_flags("t2_last_write", F_WRITE);
    tick(1);
    check_flags("t2_done_flags", F_DONE);
    check_gap = 1'b0;
    check("t2_wr_cnt", 64'(wr_cnt), 64'd4);

    // 3: over-capacity length, then recover with length 0
    pulse_start();
    send_word(32'h0000_1001);
    in_valid = 1'b0;
    check_flags("t3_err_flags", F_ERR);
    check_state("t3_err_state", ST_ERR);
    tick(3);
    check_state("t3_err_hold", ST_ERR);
    check("t3_no_write", 64'(wr_cnt), 64'd4);
    pulse_start();
    check_flags("t3_err_restart", F_RX);
    send_word(32'd0);
    in_valid = 1'b0;
    check_flags("t3_zero_done", F_DONE);
    check_state("t3_zero_state", ST_DONE);

    // exactly full capacity is accepted
    pulse_start();
    send_word(32'h0000_1000);
    in_valid = 1'b0;
    check_state("t3_max_len_ok", ST_DATA);
    #2 rst = 1'b0;
    #1 check_state("t3_max_rst", ST_IDLE);
    @(negedge clk);
    rst = 1'b1;
    tick(1);

    // 4: gapped input stream
    pulse_start();
    send_word(32'd4);
    exp_q.push_back({32'h0, 32'h33323130});
    exp_q.push_back({32'h4, 32'h37363534});
    exp_q.push_back({32'h8, 32'h3B3A3938});
    exp_q.push_back({32'hC, 32'h3F3E3D3C});
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      send_byte(8'(8'h30 + i));
    end
    in_valid = 1'b0;
    tick(2);
    check_flags("t4_done_flags", F_DONE);
    check("t4_mem0", 64'(mem_img[0]), 64'h33323130);
    check("t4_mem1", 64'(mem_img[1]), 64'h37363534);
    check("t4_mem2", 64'(mem_img[2]), 64'h3B3A3938);
    check("t4_mem3", 64'(mem_img[3]), 64'h3F3E3D3C);
    check("t4_q_empty", 64'(exp_q.size()), 64'd0);

    // 5: reset in the middle of the second word
    pulse_start();
    exp_q.push_back({32'h0, 32'h44434241});
    send_word(32'd2);
    send_byte(8'h41); send_byte(8'h42); send_byte(8'h43); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66);
    in_valid = 1'b0;
    saved_cnt = wr_cnt;
    #2 rst = 1'b0;
    #1;
    check_flags("t5_rst_flags", F_IDLE);
    check_state("t5_rst_state", ST_IDLE);
    check("t5_rst_addr", 64'(write_addr), 64'h0);
    check("t5_rst_data", 64'(write_data), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    tick(3);
    check("t5_no_partial", 64'(wr_cnt - saved_cnt), 64'd0);
    check("t5_mem0", 64'(mem_img[0]), 64'h44434241);
    check("t5_mem1_kept", 64'(mem_img[1]), 64'h37363534);
    check("t5_q_empty", 64'(exp_q.size()), 64'd0);

    // 6: start mid-DATA is ignored; start in DONE restarts
    pulse_start();
    exp_q.push_back({32'h0, 32'h04030201});
    exp_q.push_back({32'h4, 32'h08070605});
    send_word(32'd2);
    send_byte(8'h01); send_byte(8'h02);
    start = 1'b1;
    send_byte(8'h03);
    start = 1'b0;
    check_state("t6_start_ignored", ST_DATA);
    for (int i = 4; i <= 8; i++) send_byte(8'(i));
    in_valid = 1'b0;
    tick(1);
    check_flags("t6_done_flags", F_DONE);
    pulse_start();
    check_flags("t6_restart_flags", F_RX);
    check_state("t6_restart_state", ST_LEN);
    send_word(32'd0);
    in_valid = 1'b0;
    check_flags("t6_final_done", F_DONE);

    check("final_q_empty", 64'(exp_q.size()), 64'd0);
    check("final_wr_cnt", 64'(wr_cnt), 64'd11);
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
